// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch path: word size, NOP encoding,
// the {instr, pc} entry carried through the fetch buffers and fetch states.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush, used both as the
// instruction buffer and as the PC-tag queue for in-flight requests.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_data,
  input  logic                       i_pop,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wptr] <= i_push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, in-order response
// buffering and redirect flush. Misaligned-redirect trap under FETCH_MISALIGN_TRAP_EN.
//   state   | meaning
//   ST_RUN  | fetching, requests limited by credit and pending drops
//   ST_HALT | misaligned redirect taken, no fetch until an aligned redirect
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            misalign_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_drop_cnt;
  logic            w_run;
  logic            w_target_ok;
  logic [XLEN-1:0] w_target;
  logic [CW:0]     w_inflight;
  logic [CW:0]     w_occupancy;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_pop;
  fetch_entry_t    w_buf_in;
  fetch_entry_t    w_buf_head;
  fetch_entry_t    w_tag_in;
  fetch_entry_t    w_tag_head;
  logic [CW-1:0]   w_buf_count;
  logic [CW-1:0]   w_tag_count;
  logic            w_buf_full;
  logic            w_buf_empty;
  logic            w_tag_full;
  logic            w_tag_empty;
  logic [XLEN-1:0] w_unused_tag_instr;

  // Every outstanding request is either tagged or counted as a pending drop.
  assign w_inflight  = {1'b0, w_tag_count} + {1'b0, r_drop_cnt};
  assign w_occupancy = w_inflight + {1'b0, w_buf_count};

  assign imem_req_valid = rst_n && w_run && !redirect_valid &&
                          (w_occupancy < (CW+1)'(DEPTH)) &&
                          (r_drop_cnt == '0) && !w_tag_full;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_pop      = out_valid && out_ready;
  assign w_rsp_keep = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0) &&
                      !w_tag_empty && (!w_buf_full || w_pop);

  assign w_tag_in           = '{instr: INSTR_NOP, pc: r_pc};
  assign w_buf_in           = '{instr: imem_rsp_data, pc: w_tag_head.pc};
  assign w_unused_tag_instr = w_tag_head.instr;

  assign out_valid = !w_buf_empty;
  assign out_instr = w_buf_empty ? INSTR_NOP : w_buf_head.instr;
  assign out_pc    = w_buf_empty ? '0 : w_buf_head.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_e r_state;
  logic         r_fault;

  assign w_target_ok    = (redirect_pc[1:0] == 2'b00);
  assign w_target       = redirect_pc;
  assign w_run          = (r_state == ST_RUN);
  assign misalign_fault = r_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      if (w_target_ok) begin
        r_state <= ST_RUN;
        r_fault <= 1'b0;
      end else begin
        r_state <= ST_HALT;
        r_fault <= 1'b1;
      end
    end
  end
`else
  logic [1:0] w_unused_pc_lsb;

  assign w_unused_pc_lsb = redirect_pc[1:0];
  assign w_target_ok     = 1'b1;
  assign w_target        = word_align(redirect_pc);
  assign w_run           = 1'b1;
  assign misalign_fault  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      // A response landing in the redirect cycle is discarded right away.
      if (imem_rsp_valid && (w_inflight != '0))
        r_drop_cnt <= CW'(w_inflight - (CW+1)'(1));
      else
        r_drop_cnt <= CW'(w_inflight);
      if (w_target_ok) r_pc <= w_target;
    end else begin
      if (w_req_fire) r_pc <= pc_next(r_pc);
      if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_instr_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_rsp_keep),
    .i_push_data (w_buf_in),
    .i_pop       (w_pop),
    .o_head      (w_buf_head),
    .o_count     (w_buf_count),
    .o_full      (w_buf_full),
    .o_empty     (w_buf_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_tag_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_req_fire),
    .i_push_data (w_tag_in),
    .i_pop       (w_rsp_keep),
    .o_head      (w_tag_head),
    .o_count     (w_tag_count),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model plus a queue-level reference of the
// fetch stage, directed scenarios followed by a randomized phase.
module tb_fetch_unit;
  import rv32i_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_fault;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  // Each outstanding request; stale ones were overtaken by a redirect.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          stale;
  } mem_t;

  mem_t         mem_q[$];
  fetch_entry_t ref_buf[$];
  logic [31:0]  acc_addrs[$];
  logic [31:0]  del_pcs[$];
  logic [31:0]  m_pc = RESET_PC;
  bit           m_halt = 1'b0;
  bit           m_fault = 1'b0;
  int           cyc = 0;
  int           last_due = -1;
  int           lat_min = 1;
  int           lat_max = 1;

  bit           k_rst_n = 1'b0;
  bit           k_req_ready = 1'b1;
  bit           k_out_ready = 1'b1;
  bit           k_redirect = 1'b0;
  logic [31:0]  k_redirect_pc = '0;

  logic         obs_out_valid;
  logic         obs_fault;
  int           n_accepts = 0;
  int           n_checks = 0;
  int           n_fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit any_stale();
    foreach (mem_q[i]) if (mem_q[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic step();
    mem_t         e;
    fetch_entry_t fe;
    bit           rsp;
    bit           exp_req;
    bit           accept;
    bit           popped;
    bit           misaligned;
    int           due;
    @(negedge clk);
    rst_n          = k_rst_n;
    imem_req_ready = k_req_ready;
    out_ready      = k_out_ready;
    redirect_valid = k_redirect;
    redirect_pc    = k_redirect_pc;
    rsp            = k_rst_n && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_q[0].data : $urandom();
    #1;
    exp_req = k_rst_n && !m_halt && !k_redirect && !any_stale() &&
              ((mem_q.size() + ref_buf.size()) < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req || !k_rst_n) check("req_addr", imem_req_addr, m_pc);
    check("out_valid", 32'(out_valid), 32'(ref_buf.size() != 0));
    check("out_instr", out_instr, (ref_buf.size() != 0) ? ref_buf[0].instr : INSTR_NOP);
    check("out_pc", out_pc, (ref_buf.size() != 0) ? ref_buf[0].pc : 32'h0);
    check("misalign_fault", 32'(misalign_fault), 32'(m_fault));
    obs_out_valid = out_valid;
    obs_fault     = misalign_fault;
    if (imem_req_valid && imem_req_ready) begin
      n_accepts++;
      acc_addrs.push_back(imem_req_addr);
    end
    if (out_valid && out_ready && rst_n && !redirect_valid) del_pcs.push_back(out_pc);

    accept = exp_req && k_req_ready;
    popped = (ref_buf.size() != 0) && k_out_ready;
    if (!k_rst_n) begin
      mem_q.delete();
      ref_buf.delete();
      m_pc     = RESET_PC;
      m_halt   = 1'b0;
      m_fault  = 1'b0;
      last_due = cyc;
    end else begin
      if (rsp) e = mem_q.pop_front();
      if (k_redirect) begin
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        ref_buf.delete();
        misaligned = (k_redirect_pc % 4) != 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misaligned) begin
          m_halt  = 1'b1;
          m_fault = 1'b1;
        end else begin
          m_halt  = 1'b0;
          m_fault = 1'b0;
          m_pc    = k_redirect_pc;
        end
`else
        m_pc = k_redirect_pc - (k_redirect_pc % 4);
        if (misaligned) m_fault = 1'b0;
`endif
      end else begin
        if (popped) void'(ref_buf.pop_front());
        if (rsp && !e.stale) begin
          fe.instr = e.data;
          fe.pc    = e.pc;
          ref_buf.push_back(fe);
        end
        if (accept) begin
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          e.pc = m_pc; e.data = $urandom(); e.due = due; e.stale = 1'b0;
          mem_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    k_rst_n = 1'b0;
    repeat (n) step();
    k_rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] addr);
    k_redirect    = 1'b1;
    k_redirect_pc = addr;
    step();
    k_redirect    = 1'b0;
  endtask

  int snap;
  int r;

  initial begin
    // Reset state, then streaming with 1-cycle memory.
    do_reset(3);
    lat_min = 1; lat_max = 1;
    k_req_ready = 1'b1; k_out_ready = 1'b1;
    del_pcs.delete();
    repeat (10) step();
    check("stream_pc0", q_at(del_pcs, 0), 32'h0);
    check("stream_pc1", q_at(del_pcs, 1), 32'h4);
    check("stream_pc2", q_at(del_pcs, 2), 32'h8);

    // Decode stalled: only DEPTH fetches may be outstanding or buffered.
    do_reset(1);
    k_out_ready = 1'b0;
    snap = n_accepts;
    del_pcs.delete();
    repeat (10) step();
    check("stall_req_count", 32'(n_accepts - snap), 32'(DEPTH));
    check("stall_out_valid_held", 32'(obs_out_valid), 32'h1);
    k_out_ready = 1'b1;
    repeat (4) step();
    check("stall_release_pc0", q_at(del_pcs, 0), 32'h0);
    check("stall_release_pc1", q_at(del_pcs, 1), 32'h4);

    // Redirect with two fetches in flight on a 3-cycle memory.
    do_reset(1);
    lat_min = 3; lat_max = 3;
    repeat (2) step();
    del_pcs.delete();
    redirect_to(32'h0000_0100);
    for (int i = 0; i < 20 && !obs_out_valid; i++) step();
    check("redirect_out_seen", 32'(obs_out_valid), 32'h1);
    step();
    check("redirect_first_pc", q_at(del_pcs, 0), 32'h0000_0100);

    // Redirect in the same cycle as a response and a pop.
    do_reset(1);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) begin
      if ((ref_buf.size() != 0) && (mem_q.size() != 0) && (mem_q[0].due <= cyc)) break;
      step();
    end
    acc_addrs.delete();
    redirect_to(32'h0000_0040);
    step();
    check("coincide_flushed", 32'(obs_out_valid), 32'h0);
    check("coincide_next_req", q_at(acc_addrs, 0), 32'h0000_0040);
    repeat (4) step();

    // PC wrap at the top of the address space.
    acc_addrs.delete();
    redirect_to(32'hFFFF_FFFC);
    repeat (6) step();
    check("wrap_addr0", q_at(acc_addrs, 0), 32'hFFFF_FFFC);
    check("wrap_addr1", q_at(acc_addrs, 1), 32'h0000_0000);

    // Misaligned redirect target.
    acc_addrs.delete();
    snap = n_accepts;
    redirect_to(32'h0000_0102);
    repeat (6) step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("halt_no_fetch", 32'(n_accepts - snap), 32'h0);
    check("halt_fault_set", 32'(obs_fault), 32'h1);
`else
    check("misalign_fetch_aligned", q_at(acc_addrs, 0), 32'h0000_0100);
    check("misalign_fault_tied", 32'(obs_fault), 32'h0);
`endif
    acc_addrs.delete();
    redirect_to(32'h0000_0200);
    repeat (6) step();
    check("realign_fetch", q_at(acc_addrs, 0), 32'h0000_0200);
    check("realign_fault_clear", 32'(obs_fault), 32'h0);

    // Randomized traffic: variable latency, backpressure, redirects, resets.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      k_req_ready = ($urandom_range(0, 3) != 0);
      k_out_ready = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 199);
      if (r < 6) begin
        redirect_to($urandom() & 32'hFFFF_FFFC);
      end else if (r == 6) begin
        redirect_to(($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)));
      end else if (r == 7) begin
        do_reset(1);
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
